rst_seq_gen: RTL and testbench
==============================

RST_SEQ_GEN -- requirements
Module: rst_seq_gen

Interface
REQ-001 Parameter LOCK_STABLE_CYCLES, default 64: cycles locked must stay high before peripheral reset release; legal range 1..65535.
REQ-002 Parameter PERIPH_DELAY_CYCLES, default 8: cycles between peripheral release and core release; legal range 1..65535.
REQ-003 Port clk, input, 1: single clock, driven by the PLL-generated system clock; all logic on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port pll_locked_i, input, 1: PLL lock status; asynchronous to clk.
REQ-006 Port soft_rst_i, input, 1: synchronous software reset request, sampled every cycle.
REQ-007 Port periph_rst_n_o, output, 1: peripheral reset, active-low, registered.
REQ-008 Port sys_rst_n_o, output, 1: core reset, active-low, registered.
REQ-009 Port ready_o, output, 1: high only in RUN.
REQ-010 Port state_o, output, 2: current state encoding: WAIT_LOCK=0, STABLE=1, PERIPH=2, RUN=3.
REQ-011 Port loss_cnt_o, output, 8: saturating count of lock-loss events.

Function
REQ-012 pll_locked_i SHALL pass through a 2-flop synchronizer; only the synchronized value locked_s is used.
REQ-013 WAIT_LOCK: both resets asserted, counter held at 0; locked_s=1 and soft_rst_i=0 -> STABLE.
REQ-014 STABLE: counter increments each cycle; at count LOCK_STABLE_CYCLES-1 -> PERIPH with counter cleared; STABLE lasts exactly LOCK_STABLE_CYCLES cycles.
REQ-015 PERIPH: periph_rst_n_o=1, sys_rst_n_o=0; counter increments; at count PERIPH_DELAY_CYCLES-1 -> RUN.
REQ-016 RUN: both resets deasserted, ready_o=1; remains until abort.
REQ-017 Abort: locked_s=0 or soft_rst_i=1 in STABLE, PERIPH or RUN -> WAIT_LOCK on the next edge, counter cleared; both resets and ready_o go low on that same edge.
REQ-018 Abort has priority over all count-complete transitions in the same cycle.
REQ-019 Output flops SHALL be updated on the same edge as the state register, from next-state decode; no combinational path from any input to any output.
REQ-020 Latency: with locked_i rising before edge 1 and held, state enters STABLE at edge 3, periph_rst_n_o rises at edge 3+LOCK_STABLE_CYCLES, sys_rst_n_o rises at edge 3+LOCK_STABLE_CYCLES+PERIPH_DELAY_CYCLES.
REQ-021 A locked_s high pulse shorter than LOCK_STABLE_CYCLES SHALL never release either reset.
REQ-022 periph_rst_n_o SHALL never be 0 while sys_rst_n_o is 1.

Reset
REQ-023 rst_n=0 SHALL asynchronously force state WAIT_LOCK, synchronizer flops 0, counter 0, periph_rst_n_o=0, sys_rst_n_o=0, ready_o=0, state_o=0, loss_cnt_o=0.
REQ-024 Deassertion of rst_n SHALL take effect at the next clk edge; with lock already present, the sequence restarts per REQ-020.
REQ-025 rst_n assertion mid-sequence SHALL assert both reset outputs immediately, independent of clk.

Configuration
REQ-026 Macro RST_SEQ_LOSS_CNT_EN defined: loss_cnt_o increments by 1 on each cycle where locked_s=0 causes an abort from STABLE, PERIPH or RUN; it saturates at 255.
REQ-027 Under RST_SEQ_LOSS_CNT_EN, soft_rst_i aborts do not count; simultaneous soft_rst_i and lock loss count once.
REQ-028 Macro undefined: loss_cnt_o SHALL be tied to 0 and no counter flops implemented; all other behaviour is unchanged.

Verification
REQ-029 Defaults; rst_n released, pll_locked_i=1 from t0 -> periph_rst_n_o rises at edge 67, sys_rst_n_o and ready_o rise at edge 75, state_o=3.
REQ-030 pll_locked_i high for 30 cycles, then low -> both resets stay 0 throughout; state_o returns to 0; loss_cnt_o=1 (macro on).
REQ-031 In RUN, pll_locked_i low for 1 cycle -> resets low 3 edges later; relock yields the full 64+8 sequence again; loss_cnt_o increments.
REQ-032 In PERIPH, soft_rst_i pulse with lock held -> WAIT_LOCK next edge, sys_rst_n_o never rises early, loss_cnt_o unchanged.
REQ-033 300 lock-loss events -> loss_cnt_o=255 (macro on); identical run with macro off -> loss_cnt_o=0.
REQ-034 rst_n pulsed low between clk edges while in RUN -> all outputs 0 before the next edge; the sequence restarts per REQ-020.

Source files
------------

// File: rtl/rst_seq_gen.sv
// rst_seq_gen: power-on / lock-driven reset sequencer.
// Waits for a stable PLL lock, releases the peripheral reset, then after a
// further delay releases the core reset and flags ready. Any lock loss or
// software reset request drops everything back to WAIT_LOCK.
//
// Optional build macro: RST_SEQ_LOSS_CNT_EN enables the saturating lock-loss
// counter on loss_cnt_o; without it loss_cnt_o is tied to 0.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// WAIT_LOCK  | both resets asserted, waiting for synchronized lock
// STABLE     | lock seen, counting LOCK_STABLE_CYCLES of continuous lock
// PERIPH     | peripheral reset released, counting PERIPH_DELAY_CYCLES
// RUN        | both resets released, ready_o high

module rst_seq_gen #(
  parameter int unsigned LOCK_STABLE_CYCLES  = 64,
  parameter int unsigned PERIPH_DELAY_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked_i,
  input  logic       soft_rst_i,
  output logic       periph_rst_n_o,
  output logic       sys_rst_n_o,
  output logic       ready_o,
  output logic [1:0] state_o,
  output logic [7:0] loss_cnt_o
);

  localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] ST_STABLE    = 2'd1;
  localparam logic [1:0] ST_PERIPH    = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  // Terminal counts: the counter runs 0..N-1 so each phase lasts exactly N cycles.
  localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE_CYCLES - 1);
  localparam logic [15:0] PERIPH_LAST = 16'(PERIPH_DELAY_CYCLES - 1);

  logic        sync_q1;
  logic        locked_s;
  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        abort;

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1  <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_q1  <= pll_locked_i;
      locked_s <= sync_q1;
    end
  end

  assign abort = !locked_s || soft_rst_i;

  // Next-state and counter decode; abort outranks every terminal-count exit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        cnt_d = '0;
        if (locked_s && !soft_rst_i) state_d = ST_STABLE;
      end
      ST_STABLE: begin
        if (abort) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_PERIPH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_PERIPH: begin
        if (abort) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == PERIPH_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (abort) state_d = ST_WAIT_LOCK;
      end
      default: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and outputs share one edge; outputs decode from state_d
  // so they change together with the state and never see inputs directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_WAIT_LOCK;
      cnt_q          <= '0;
      periph_rst_n_o <= 1'b0;
      sys_rst_n_o    <= 1'b0;
      ready_o        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      periph_rst_n_o <= (state_d == ST_PERIPH) || (state_d == ST_RUN);
      sys_rst_n_o    <= (state_d == ST_RUN);
      ready_o        <= (state_d == ST_RUN);
    end
  end

  assign state_o = state_q;

`ifdef RST_SEQ_LOSS_CNT_EN
  logic       lock_loss;
  logic [7:0] loss_cnt_q;

  // Only lock-driven aborts count; soft resets are deliberate, not faults.
  assign lock_loss = (state_q != ST_WAIT_LOCK) && !locked_s;

  // Saturating lock-loss event counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt_q <= '0;
    end else if (lock_loss && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_q <= loss_cnt_q + 8'd1;
    end
  end

  assign loss_cnt_o = loss_cnt_q;
`else
  assign loss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_rst_seq_gen.sv
// Testbench for rst_seq_gen: randomized and directed stimulus checked against
// a phase/elapsed-time reference model of the reset sequence.

module tb_rst_seq_gen;

  localparam int L = 64;
  localparam int P = 8;
`ifdef RST_SEQ_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       pll_locked_i;
  logic       soft_rst_i;
  logic       periph_rst_n_o;
  logic       sys_rst_n_o;
  logic       ready_o;
  logic [1:0] state_o;
  logic [7:0] loss_cnt_o;

  int cmp_count = 0;
  int err_count = 0;

  // Reference model: is a sequence in progress, how many cycles since it
  // entered the stable-lock phase, lock-loss tally, and lock sample history.
  bit m_active;
  int m_elapsed;
  int m_loss;
  bit h0, h1;

  rst_seq_gen #(
    .LOCK_STABLE_CYCLES (L),
    .PERIPH_DELAY_CYCLES(P)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pll_locked_i  (pll_locked_i),
    .soft_rst_i    (soft_rst_i),
    .periph_rst_n_o(periph_rst_n_o),
    .sys_rst_n_o   (sys_rst_n_o),
    .ready_o       (ready_o),
    .state_o       (state_o),
    .loss_cnt_o    (loss_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_state();
    if (!m_active) return 0;
    if (m_elapsed < L) return 1;
    if (m_elapsed < L + P) return 2;
    return 3;
  endfunction

  function automatic logic [12:0] exp_vec();
    int s;
    s = exp_state();
    return {2'(s), s >= 2, s == 3, s == 3, LOSS_EN ? 8'(m_loss) : 8'd0};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {state_o, periph_rst_n_o, sys_rst_n_o, ready_o, loss_cnt_o};
  endfunction

  task automatic model_clear();
    m_active  = 1'b0;
    m_elapsed = 0;
    m_loss    = 0;
    h0        = 1'b0;
    h1        = 1'b0;
  endtask

  // One clock edge: advance the model using the lock value seen two edges ago.
  task automatic step();
    bit ls;
    @(posedge clk);
    ls = h1;
    if (!m_active) begin
      if (ls && !soft_rst_i) begin
        m_active  = 1'b1;
        m_elapsed = 0;
      end
    end else if (!ls || soft_rst_i) begin
      m_active = 1'b0;
      if (!ls && m_loss < 255) m_loss++;
    end else if (m_elapsed < L + P) begin
      m_elapsed++;
    end
    h1 = h0;
    h0 = pll_locked_i;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int edge_n;
    rst_n        = 1'b0;
    pll_locked_i = 1'b1;
    soft_rst_i   = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    cmp_count++;
    if (dut_vec() !== 13'd0) begin
      err_count++;
      $display("FAIL reset_state: got %h want 0", dut_vec());
    end
    rst_n = 1'b1;
    for (edge_n = 1; edge_n <= 3 + L + P + 2; edge_n++) begin
      step();
      cmp_count++;
      if (dut_vec() !== exp_vec()) begin
        err_count++;
        $display("FAIL reset_seq edge %0d: got %h want %h", edge_n, dut_vec(), exp_vec());
      end
      if (edge_n == 2 + L || edge_n == 3 + L) begin
        cmp_count++;
        if (periph_rst_n_o !== (edge_n == 3 + L)) begin
          err_count++;
          $display("FAIL periph_release edge %0d: got %b want %b", edge_n, periph_rst_n_o, edge_n == 3 + L);
        end
      end
      if (edge_n == 2 + L + P || edge_n == 3 + L + P) begin
        cmp_count++;
        if ({sys_rst_n_o, ready_o} !== {2{edge_n == 3 + L + P}}) begin
          err_count++;
          $display("FAIL sys_release edge %0d: got %b%b", edge_n, sys_rst_n_o, ready_o);
        end
      end
    end
    cmp_count++;
    if (state_o !== 2'd3) begin
      err_count++;
      $display("FAIL run_state: got %0d want 3", state_o);
    end
  endtask

  task automatic test_short_lock();
    pll_locked_i = 1'b1;
    soft_rst_i   = 1'b0;
    do_reset();
    for (int i = 0; i < 70; i++) begin
      if (i == 30) pll_locked_i = 1'b0;
      step();
      cmp_count++;
      if (dut_vec() !== exp_vec() || periph_rst_n_o !== 1'b0 || sys_rst_n_o !== 1'b0) begin
        err_count++;
        $display("FAIL short_lock cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    cmp_count++;
    if (state_o !== 2'd0 || loss_cnt_o !== (LOSS_EN ? 8'd1 : 8'd0)) begin
      err_count++;
      $display("FAIL short_lock_end: state %0d loss %0d want 0/%0d", state_o, loss_cnt_o, LOSS_EN);
    end
  endtask

  task automatic test_run_glitch();
    int loss0;
    int rise;
    pll_locked_i = 1'b1;
    soft_rst_i   = 1'b0;
    do_reset();
    repeat (3 + L + P) step();
    loss0 = m_loss;
    cmp_count++;
    if (ready_o !== 1'b1) begin
      err_count++;
      $display("FAIL glitch_pre_run: ready %b want 1", ready_o);
    end
    pll_locked_i = 1'b0;
    rise = -1;
    for (int e = 1; e <= 4 + L + P + 2; e++) begin
      step();
      if (e == 1) pll_locked_i = 1'b1;
      cmp_count++;
      if (dut_vec() !== exp_vec()) begin
        err_count++;
        $display("FAIL glitch edge %0d: got %h want %h", e, dut_vec(), exp_vec());
      end
      if (e <= 3) begin
        cmp_count++;
        if ({periph_rst_n_o, sys_rst_n_o, ready_o} !== {3{e < 3}}) begin
          err_count++;
          $display("FAIL glitch_drop edge %0d: got %b%b%b", e, periph_rst_n_o, sys_rst_n_o, ready_o);
        end
      end
      if (rise < 0 && e > 3 && periph_rst_n_o === 1'b1) rise = e;
    end
    cmp_count++;
    if (rise != 4 + L) begin
      err_count++;
      $display("FAIL glitch_relock: periph rose at edge %0d want %0d", rise, 4 + L);
    end
    cmp_count++;
    if (ready_o !== 1'b1 || loss_cnt_o !== 8'(LOSS_EN ? loss0 + 1 : 0)) begin
      err_count++;
      $display("FAIL glitch_end: ready %b loss %0d", ready_o, loss_cnt_o);
    end
  endtask

  task automatic test_soft_periph();
    logic [7:0] loss0;
    pll_locked_i = 1'b1;
    soft_rst_i   = 1'b0;
    do_reset();
    repeat (3 + L + 2) step();
    loss0 = loss_cnt_o;
    cmp_count++;
    if (state_o !== 2'd2) begin
      err_count++;
      $display("FAIL soft_pre: state %0d want 2", state_o);
    end
    soft_rst_i = 1'b1;
    step();
    soft_rst_i = 1'b0;
    cmp_count++;
    if (state_o !== 2'd0 || periph_rst_n_o !== 1'b0 || sys_rst_n_o !== 1'b0 || loss_cnt_o !== loss0) begin
      err_count++;
      $display("FAIL soft_abort: state %0d p %b s %b loss %0d", state_o, periph_rst_n_o, sys_rst_n_o, loss_cnt_o);
    end
    for (int i = 1; i <= L + P + 1; i++) begin
      step();
      cmp_count++;
      if (dut_vec() !== exp_vec() || sys_rst_n_o !== (i == L + P + 1)) begin
        err_count++;
        $display("FAIL soft_reseq cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int cyc;
    int len;
    pll_locked_i = 1'b0;
    soft_rst_i   = 1'b0;
    do_reset();
    cyc = 0;
    while (cyc < 3000) begin
      pll_locked_i = ~pll_locked_i;
      len = pll_locked_i ? int'($urandom_range(1, 120)) : int'($urandom_range(1, 5));
      for (int i = 0; i < len; i++) begin
        soft_rst_i = ($urandom_range(0, 149) == 0);
        step();
        cyc++;
        cmp_count++;
        if (dut_vec() !== exp_vec() || (periph_rst_n_o === 1'b0 && sys_rst_n_o === 1'b1)) begin
          err_count++;
          $display("FAIL random cyc %0d: got %h want %h", cyc, dut_vec(), exp_vec());
        end
      end
    end
    soft_rst_i = 1'b0;
  endtask

  task automatic test_saturate();
    pll_locked_i = 1'b0;
    soft_rst_i   = 1'b0;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      pll_locked_i = 1'b1;
      repeat (5) step();
      pll_locked_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
        step();
        cmp_count++;
        if (dut_vec() !== exp_vec()) begin
          err_count++;
          $display("FAIL saturate ev %0d: got %h want %h", n, dut_vec(), exp_vec());
        end
      end
    end
    cmp_count++;
    if (loss_cnt_o !== (LOSS_EN ? 8'd255 : 8'd0)) begin
      err_count++;
      $display("FAIL saturate_end: loss %0d want %0d", loss_cnt_o, LOSS_EN ? 255 : 0);
    end
  endtask

  task automatic test_async_reset();
    pll_locked_i = 1'b1;
    soft_rst_i   = 1'b0;
    do_reset();
    repeat (3 + L + P) step();
    #3;
    rst_n = 1'b0;
    #1;
    cmp_count++;
    if (dut_vec() !== 13'd0) begin
      err_count++;
      $display("FAIL async_reset: got %h want 0", dut_vec());
    end
    #1;
    model_clear();
    rst_n = 1'b1;
    for (int e = 1; e <= 3 + L + P; e++) begin
      step();
      cmp_count++;
      if (dut_vec() !== exp_vec()) begin
        err_count++;
        $display("FAIL async_restart edge %0d: got %h want %h", e, dut_vec(), exp_vec());
      end
    end
    cmp_count++;
    if (ready_o !== 1'b1 || state_o !== 2'd3) begin
      err_count++;
      $display("FAIL async_restart_end: ready %b state %0d", ready_o, state_o);
    end
  endtask

  initial begin
    test_reset();
    test_short_lock();
    test_run_glitch();
    test_soft_periph();
    test_random();
    test_saturate();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before end of tests");
    $fatal(1, "watchdog");
  end

endmodule
